// File: rtl/seq_arb_4in_wrr.sv
// Four-input weighted round-robin arbiter; each requester may hold the grant for up to weight+1 cycles.
// Optional SEQ_ARB_WRR_LOCK_EN adds a lock input that stretches the current tenure.
module seq_arb_4in_wrr #(
    parameter int unsigned WBITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             reqs,
    input  logic [4*WBITS-1:0]     weights,
    input  logic                   cfg_load,
`ifdef SEQ_ARB_WRR_LOCK_EN
    input  logic                   lock,
`endif
    output logic [3:0]             grants
);

    localparam logic [WBITS-1:0] CntOne = WBITS'(1);

    logic [3:0]             r_prio;
    logic                   r_ov;
    logic [1:0]             r_own;
    logic [WBITS-1:0]       r_cnt;
    logic [3:0][WBITS-1:0]  r_wreg;

    logic [1:0]             w_pidx;
    logic [3:0]             w_rot;
    logic [1:0]             w_off;
    logic                   w_hold;
    logic                   w_gnt_v;
    logic [1:0]             w_gidx;
    logic [1:0]             w_next;
    logic [WBITS-1:0]       w_base;
    logic                   w_lock;

`ifdef SEQ_ARB_WRR_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    always_comb begin
        w_pidx = 2'd0;
        unique case (r_prio)
            4'b0001: w_pidx = 2'd0;
            4'b0010: w_pidx = 2'd1;
            4'b0100: w_pidx = 2'd2;
            4'b1000: w_pidx = 2'd3;
            default: w_pidx = 2'd0;
        endcase
    end

    // Rotate requests so bit 0 is the current priority holder, then pick the lowest set bit.
    always_comb begin
        w_rot = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_rot[k] = reqs[2'(w_pidx + 2'(k))];
        end
        w_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 2'(k);
            end
        end
    end

    always_comb begin
        w_hold  = r_ov && reqs[r_own];
        w_gnt_v = |reqs;
        w_gidx  = w_hold ? r_own : 2'(w_pidx + w_off);
        w_next  = 2'(w_gidx + 2'd1);
        w_base  = (r_ov && (r_own == w_gidx)) ? r_cnt : '0;
        grants  = (reset && w_gnt_v) ? (4'b0001 << w_gidx) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= 4'b0001;
            r_ov   <= 1'b0;
            r_own  <= 2'd0;
            r_cnt  <= '0;
            r_wreg <= '0;
        end else begin
            if (w_gnt_v) begin
                r_prio <= 4'b0001 << w_next;
                if (w_lock) begin
                    r_ov  <= 1'b1;
                    r_own <= w_gidx;
                    r_cnt <= w_base;
                end else if (w_base == r_wreg[w_gidx]) begin
                    r_ov  <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_ov  <= 1'b1;
                    r_own <= w_gidx;
                    r_cnt <= w_base + CntOne;
                end
            end else begin
                r_ov  <= 1'b0;
                r_cnt <= '0;
            end
            // A weight reload always ends the running tenure, overriding the update above.
            if (cfg_load) begin
                r_wreg <= weights;
                r_ov   <= 1'b0;
                r_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seq_arb_4in_wrr.sv
// Bench for seq_arb_4in_wrr: directed scenarios with literal expectations plus randomized traffic
// checked against a grant-budget reference model.
module tb_seq_arb_4in_wrr;

    logic        clk;
    logic        reset;
    logic [3:0]  reqs;
    logic [11:0] weights;
    logic        cfg_load;
    logic [3:0]  grants;
`ifdef SEQ_ARB_WRR_LOCK_EN
    logic        lock;
`endif

    int n_vec;
    int n_err;

    // Model: priority index, current owner (-1 none), grants still allowed in this tenure.
    int m_prio;
    int m_owner;
    int m_left;
    int m_w[4];

    seq_arb_4in_wrr #(.WBITS(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .reqs     (reqs),
        .weights  (weights),
        .cfg_load (cfg_load),
`ifdef SEQ_ARB_WRR_LOCK_EN
        .lock     (lock),
`endif
        .grants   (grants)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_prio  = 0;
        m_owner = -1;
        m_left  = 0;
        for (int i = 0; i < 4; i++) m_w[i] = 0;
    endfunction

    function automatic int model_pick(input logic [3:0] r, input logic rn);
        if (!rn) return -1;
        if (m_owner >= 0 && r[m_owner]) return m_owner;
        for (int k = 0; k < 4; k++) begin
            if (r[(m_prio + k) % 4]) return (m_prio + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic c, input logic [11:0] w,
                                       input logic rn, input logic lk);
        int g;
        if (!rn) begin
            model_reset();
            return;
        end
        g = model_pick(r, rn);
        if (g < 0) begin
            m_owner = -1;
        end else begin
            if (m_owner != g) m_left = m_w[g] + 1;
            if (!lk) m_left--;
            m_owner = (m_left == 0) ? -1 : g;
            m_prio = (g + 1) % 4;
        end
        if (c) begin
            for (int i = 0; i < 4; i++) m_w[i] = int'(w[i*3 +: 3]);
            m_owner = -1;
        end
    endfunction

    // Drives one cycle just after a posedge, checks grants mid-cycle, then advances the model.
    task automatic do_cycle(input logic [3:0] r, input logic c, input logic [11:0] w,
                            input logic rn, input logic lk, output logic [3:0] got);
        int g;
        logic [3:0] exp;
        reqs     = r;
        cfg_load = c;
        weights  = w;
        reset    = rn;
`ifdef SEQ_ARB_WRR_LOCK_EN
        lock     = lk;
`endif
        #3;
        g   = model_pick(r, rn);
        exp = (g < 0) ? 4'b0000 : 4'(1 << g);
        got = grants;
        check_eq("model", got, exp);
        @(posedge clk);
        model_step(r, c, w, rn, lk);
        #1;
    endtask

    task automatic plan(input string tag, input logic [3:0] r, input logic c, input logic [11:0] w,
                        input logic rn, input logic lk, input logic [3:0] exp);
        logic [3:0] got;
        do_cycle(r, c, w, rn, lk, got);
        check_eq(tag, got, exp);
    endtask

    task automatic start(input logic [11:0] w, input logic do_load);
        plan("reset0", 4'b1111, 1'b0, 12'h0, 1'b0, 1'b0, 4'b0000);
        plan("reset1", 4'b1111, 1'b0, 12'h0, 1'b0, 1'b0, 4'b0000);
        if (do_load) plan("load", 4'b0000, 1'b1, w, 1'b1, 1'b0, 4'b0000);
    endtask

    logic [3:0]  seq_w[10];
    logic [3:0]  rr_seq[4];
    logic [3:0]  r_rand;
    logic [11:0] w_rand;
    logic [3:0]  got;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        reqs     = 4'b0000;
        weights  = 12'h0;
        cfg_load = 1'b0;
`ifdef SEQ_ARB_WRR_LOCK_EN
        lock     = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        #1;

        // Plain round-robin
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        start(12'h0, 1'b0);
        for (int i = 0; i < 8; i++) plan("rr", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, rr_seq[i % 4]);

        // Weighted tenure: w0=2, w1=1
        seq_w = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000,
                  4'b0001, 4'b0001, 4'b0001};
        start({3'd0, 3'd0, 3'd1, 3'd2}, 1'b1);
        for (int i = 0; i < 10; i++) plan("wrr", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, seq_w[i]);

        // Owner drop and idle
        start({3'd0, 3'd0, 3'd0, 3'd3}, 1'b1);
        plan("drop_a", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0001);
        plan("drop_b", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0001);
        plan("drop_c", 4'b1110, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0010);
        plan("idle",   4'b0000, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0000);
        plan("resume", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0100);

        // Reset mid-tenure clears the weights
        start({3'd0, 3'd0, 3'd0, 3'd3}, 1'b1);
        plan("mrst_a", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0001);
        plan("mrst_b", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0001);
        plan("mrst_c", 4'b1111, 1'b0, 12'h0, 1'b0, 1'b0, 4'b0000);
        plan("mrst_d", 4'b1111, 1'b0, 12'h0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) plan("mrst_rr", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, rr_seq[i]);

        // Reload mid-tenure
        start({3'd0, 3'd0, 3'd0, 3'd3}, 1'b1);
        plan("rld_a", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0001);
        plan("rld_b", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0001);
        plan("rld_c", 4'b1111, 1'b1, 12'h0, 1'b1, 1'b0, 4'b0001);
        plan("rld_d", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0010);
        plan("rld_e", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0100);

`ifdef SEQ_ARB_WRR_LOCK_EN
        start(12'h0, 1'b0);
        for (int i = 0; i < 3; i++) plan("lock", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b1, 4'b0001);
        plan("unlock_a", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0001);
        plan("unlock_b", 4'b1111, 1'b0, 12'h0, 1'b1, 1'b0, 4'b0010);
`endif

        // Randomized traffic with sticky requests so tenures actually run
        r_rand = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            logic c;
            logic rn;
            logic lk;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r_rand[b] = ~r_rand[b];
            end
            w_rand = 12'($urandom);
            c  = ($urandom_range(11) == 0);
            rn = ($urandom_range(59) != 0);
`ifdef SEQ_ARB_WRR_LOCK_EN
            lk = ($urandom_range(4) == 0);
`else
            lk = 1'b0;
`endif
            do_cycle(r_rand, c, w_rand, rn, lk, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
